// File: rtl/reg_bank_2r1w.sv
// Two-read, one-write register bank with a multi-cycle clear walk and per-register dirty bits.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_bank_2r1w #(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 3,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            WriteEn,
  input  logic [D-1:0]    Waddr,
  input  logic [W-1:0]    DataIn,
  input  logic [D-1:0]    RaddrA,
  input  logic [D-1:0]    RaddrB,
  output logic [W-1:0]    DataOutA,
  output logic [W-1:0]    DataOutB,
  input  logic            Clear,
  output logic            Busy,
  output logic [2**D-1:0] Dirty
);

  localparam int unsigned Depth = 2**D;

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [D-1:0]     ptr_q, ptr_d;
  logic [W-1:0]     regs_q [Depth];
  logic [W-1:0]     regs_d [Depth];
  logic [Depth-1:0] dirty_q, dirty_d;
  logic             wr_ok;

  // A write is dropped when a clear is requested on the same edge.
  assign wr_ok = (state_q == StIdle) && WriteEn && !Clear &&
                 !((ZERO_R0 != 0) && (Waddr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    dirty_d = dirty_q;
    unique case (state_q)
      StIdle: begin
        if (Clear) begin
          state_d = StClear;
          ptr_d   = '0;
        end else if (wr_ok) begin
          regs_d[Waddr]  = DataIn;
          dirty_d[Waddr] = 1'b1;
        end
      end
      StClear: begin
        regs_d[ptr_q]  = '0;
        dirty_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + D'(1);
        if (ptr_q == D'(Depth - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      dirty_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dirty_q <= dirty_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    DataOutA = regs_q[RaddrA];
`ifdef REG_BANK_BYPASS_EN
    if (wr_ok && (RaddrA == Waddr)) begin
      DataOutA = DataIn;
    end
`endif
    if ((ZERO_R0 != 0) && (RaddrA == '0)) begin
      DataOutA = '0;
    end
  end

  always_comb begin
    DataOutB = regs_q[RaddrB];
`ifdef REG_BANK_BYPASS_EN
    if (wr_ok && (RaddrB == Waddr)) begin
      DataOutB = DataIn;
    end
`endif
    if ((ZERO_R0 != 0) && (RaddrB == '0)) begin
      DataOutB = '0;
    end
  end

  assign Busy  = (state_q == StClear);
  assign Dirty = dirty_q;

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Bench for reg_bank_2r1w: two instances (ZERO_R0 = 0 and 1) checked every cycle against
// an array/queue model, plus directed literal checks.
module tb_reg_bank_2r1w;

  logic       Clk, ResetN, WriteEn, Clear;
  logic [2:0] Waddr, RaddrA, RaddrB;
  logic [7:0] DataIn;
  logic [7:0] oa0, ob0, oa1, ob1;
  logic       busy0, busy1;
  logic [7:0] dirty0, dirty1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  reg_bank_2r1w #(.W(8), .D(3), .ZERO_R0(0)) u_dut (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(oa0), .DataOutB(ob0),
    .Clear(Clear), .Busy(busy0), .Dirty(dirty0)
  );

  reg_bank_2r1w #(.W(8), .D(3), .ZERO_R0(1)) u_dut_z (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(oa1), .DataOutB(ob1),
    .Clear(Clear), .Busy(busy1), .Dirty(dirty1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 is the plain bank, index 1 the zero-register bank.
  logic [7:0] m_mem   [2][8];
  bit         m_dirty [2][8];
  int         walk_q  [$];

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int z = 0; z < 2; z++) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[z][i]   <= 8'h00;
          m_dirty[z][i] <= 1'b0;
        end
      end
      walk_q.delete();
    end else if (walk_q.size() != 0) begin
      for (int z = 0; z < 2; z++) begin
        m_mem[z][walk_q[0]]   <= 8'h00;
        m_dirty[z][walk_q[0]] <= 1'b0;
      end
      void'(walk_q.pop_front());
    end else if (Clear) begin
      for (int i = 0; i < 8; i++) walk_q.push_back(i);
    end else if (WriteEn) begin
      for (int z = 0; z < 2; z++) begin
        if (!(z == 1 && Waddr == 3'd0)) begin
          m_mem[z][Waddr]   <= DataIn;
          m_dirty[z][Waddr] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_rd(input int z, input logic [2:0] a);
    if (z == 1 && a == 3'd0) return 8'h00;
`ifdef REG_BANK_BYPASS_EN
    if (walk_q.size() == 0 && WriteEn && !Clear && a == Waddr) return DataIn;
`endif
    return m_mem[z][a];
  endfunction

  function automatic logic [7:0] exp_dirty(input int z);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_dirty[z][i];
    return v;
  endfunction

  always @(negedge Clk) begin
    if (ResetN && chk_en) begin
      chk("rdA_z0", oa0, exp_rd(0, RaddrA));
      chk("rdB_z0", ob0, exp_rd(0, RaddrB));
      chk("busy_z0", busy0, walk_q.size() != 0);
      chk("dirty_z0", dirty0, exp_dirty(0));
      chk("rdA_z1", oa1, exp_rd(1, RaddrA));
      chk("rdB_z1", ob1, exp_rd(1, RaddrB));
      chk("busy_z1", busy1, walk_q.size() != 0);
      chk("dirty_z1", dirty1, exp_dirty(1));
    end
  end

  // Inputs change 2 ns after the falling edge, so compares at the falling edge see stable values.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] din,
                     input logic clr, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge Clk);
    #2;
    WriteEn = we;
    Waddr   = wa;
    DataIn  = din;
    Clear   = clr;
    RaddrA  = ra;
    RaddrB  = rb;
  endtask

  // Call right after the edge that accepts Clear; returns the number of Busy cycles seen.
  task automatic walk_measure(input bit mid_events, output int len);
    len = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(mid_events && k == 3, 3'd1, 8'hEE, mid_events && k == 3, 3'(k - 1), 3'd7);
      #1;
      if (k >= 1 && k <= 8) chk("walked_zero", oa0, 8'h00);
      if (busy0) len++;
      else if (k > 0) break;
    end
  endtask

  int len;

  initial begin
    ResetN = 1'b0;
    WriteEn = 1'b0; Clear = 1'b0; Waddr = 3'd0; DataIn = 8'h00; RaddrA = 3'd0; RaddrB = 3'd0;
    #1;
    chk("reset_busy", busy0, 1'b0);
    chk("reset_dirty", dirty0, 8'h00);
    chk("reset_rdA", oa0, 8'h00);
    @(negedge Clk);
    #2;
    ResetN = 1'b1;
    chk_en = 1'b1;

    // Single write, read back on both ports.
    cyc(1'b1, 3'd3, 8'hA5, 1'b0, 3'd3, 3'd3);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd3);
    #1;
    chk("wr3_rdA", oa0, 8'hA5);
    chk("wr3_rdB", ob0, 8'hA5);
    chk("wr3_dirty", dirty0, 8'b0000_1000);

    // Fill every register with i*17+1.
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'(i * 17 + 1), 1'b0, 3'(i), 3'd3);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd7);
    #1;
    chk("fill_rd2", oa0, 8'h23);
    chk("fill_rd7", ob0, 8'h78);
    chk("fill_dirty", dirty0, 8'hFF);
    chk("fill_dirty_z", dirty1, 8'hFE);

    // Same-cycle read of the address being written.
    cyc(1'b1, 3'd2, 8'h77, 1'b0, 3'd2, 3'd5);
`ifdef REG_BANK_BYPASS_EN
    #1 chk("bypass_rdA", oa0, 8'h77);
`else
    #1 chk("nobypass_rdA", oa0, 8'h23);
`endif

    // Writes to register 0 are discarded on the zero-register bank.
    cyc(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd0);
    #1 chk("z_rd0_same", oa1, 8'h00);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2);
    #1;
    chk("z_rd0", oa1, 8'h00);
    chk("z_dirty0", dirty1[0], 1'b0);
    chk("nz_rd0", oa0, 8'hFF);
    chk("after_wr2", ob0, 8'h77);

    // Clear walk: Busy for exactly 8 cycles, all dirty bits drop.
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7);
    walk_measure(1'b0, len);
    chk("busy_len", len, 8);
    chk("clear_dirty", dirty0, 8'h00);

    // Clear beats a simultaneous write; mid-walk Clear/WriteEn are ignored.
    cyc(1'b1, 3'd5, 8'h99, 1'b0, 3'd5, 3'd5);
    cyc(1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 3'd5);
    walk_measure(1'b1, len);
    chk("busy_len_retrig", len, 8);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd1);
    #1;
    chk("collide_rd5", oa0, 8'h00);
    chk("midwalk_wr_rd1", ob0, 8'h00);
    chk("collide_dirty", dirty0, 8'h00);

    // Reset asserted four cycles into a walk.
    cyc(1'b1, 3'd4, 8'h44, 1'b0, 3'd4, 3'd7);
    cyc(1'b1, 3'd7, 8'h7E, 1'b0, 3'd4, 3'd7);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd7);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd4);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd4);
    #1;
    chk("prereset_busy", busy0, 1'b1);
    chk("prereset_rd7", oa0, 8'h7E);
    ResetN = 1'b0;
    #1;
    chk("async_busy", busy0, 1'b0);
    chk("async_dirty", dirty0, 8'h00);
    chk("async_rd7", oa0, 8'h00);
    chk("async_rd4", ob0, 8'h00);
    cyc(1'b1, 3'd4, 8'h5A, 1'b0, 3'd4, 3'd7);
    ResetN = 1'b1;
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd7);
    #1;
    chk("post_busy", busy0, 1'b0);
    chk("post_wr4", oa0, 8'h5A);
    chk("post_rd7", ob0, 8'h00);
    chk("post_dirty", dirty0, 8'b0001_0000);

    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/reg_bank_2r1w.md
REG_BANK_2R1W -- requirements
Module: reg_bank_2r1w

Interface
REQ-001 SHALL have parameter W, default 8: data word width in bits.
REQ-002 SHALL have parameter D, default 3: address width; depth is 2**D registers.
REQ-003 SHALL have parameter ZERO_R0, default 0: when 1, register 0 is hardwired to zero.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 ResetN  input  1  reset, asynchronous and active-low.
REQ-006 WriteEn  input  1  write request for the current cycle.
REQ-007 Waddr  input  D  write address.
REQ-008 DataIn  input  W  write data.
REQ-009 RaddrA, RaddrB  input  D each  read addresses for ports A and B.
REQ-010 DataOutA, DataOutB  output  W each  combinational read data.
REQ-011 Clear  input  1  single-cycle request to zero the whole bank.
REQ-012 Busy  output  1  high while a clear walk is in progress.
REQ-013 Dirty  output  2**D  bit i high when register i has been written since the last reset or clear.

Function
REQ-014 Reads SHALL be combinational and zero-latency, with DataOutX = Registers[RaddrX] for both ports independently.
REQ-015 In IDLE with WriteEn=1 and Clear=0, the bank SHALL write Registers[Waddr] <= DataIn and set Dirty[Waddr] on the rising edge.
REQ-016 When ZERO_R0=1, the bank SHALL ignore writes to address 0 (Dirty[0] stays 0), and any read of address 0 SHALL return 0.
REQ-017 The FSM SHALL have exactly two states, IDLE and CLEAR, plus a D-bit walk pointer Ptr.
REQ-018 In IDLE, Clear=1 sampled on an edge SHALL cause a transition to CLEAR with Ptr <= 0 and Busy=1 from the next cycle.
REQ-019 In CLEAR, each edge SHALL perform Registers[Ptr] <= 0 and Dirty[Ptr] <= 0, then Ptr <= Ptr+1.
REQ-020 The edge on which Ptr==2**D-1 SHALL return the FSM to IDLE, so Busy is high for exactly 2**D cycles.
REQ-021 Busy SHALL be a registered output equal to (state==CLEAR).
REQ-022 Clear=1 and WriteEn=1 on the same IDLE edge: the clear SHALL win, and the write SHALL be dropped.
REQ-023 While in CLEAR, the bank SHALL ignore WriteEn and Clear, and SHALL NOT restart the walk.
REQ-024 Reads during CLEAR SHALL return current array contents, i.e. zero for already-walked addresses and old data otherwise.
REQ-025 The bank SHALL NOT modify any register other than the one addressed on any edge.

Reset
REQ-026 ResetN=0 SHALL immediately, without a clock edge, force all registers to 0, Dirty to 0, state to IDLE, Ptr to 0 and Busy to 0.
REQ-027 Reset asserted mid-walk SHALL abort the walk; after deassertion the bank SHALL be in IDLE with all registers zero.
REQ-028 The first edge after ResetN rises SHALL accept a write or a clear normally.

Configuration
REQ-029 The macro REG_BANK_BYPASS_EN, when defined, SHALL enable write-to-read bypass: in IDLE with WriteEn=1 and RaddrX==Waddr, DataOutX SHALL equal DataIn in the same cycle.
REQ-030 Bypass SHALL be subject to the ZERO_R0 rule, and SHALL be inactive during CLEAR or when the write is dropped (REQ-022).
REQ-031 Without REG_BANK_BYPASS_EN, reads SHALL return the pre-edge array contents, and new data SHALL be visible only from the cycle after the write.

Verification
REQ-032 Reset, then write 0xA5 to addr 3, then read A=3 and B=3 next cycle -> both 0xA5 and Dirty=8'b0000_1000.
REQ-033 With D=3, write all 8 regs, pulse Clear -> Busy=1 for exactly 8 cycles; after each edge the walked address reads 0; finally Dirty=0.
REQ-034 Clear and WriteEn (addr 5, 0x3C) on the same edge -> walk starts, reg 5 ends 0, no write occurs; a second Clear mid-walk -> walk length still 8.
REQ-035 ZERO_R0=1, write 0xFF to addr 0 -> read addr 0 returns 0 and Dirty[0]=0.
REQ-036 Bypass: WriteEn addr 2 data 0x77 with RaddrA=2 -> DataOutA=0x77 in the same cycle with the macro defined, and the old value without it.
REQ-037 Assert ResetN low at walk cycle 4 -> all outputs 0 asynchronously, and Busy=0 after release.
